// File: rtl/tmr_timeout_ctrl_pkg.sv
// Shared definitions for the timeout controller.
// state_e : controller FSM state encoding (IDLE, CLEAR, RUN, EXPIRE).
// StateW  : bit width of the state encoding, used to size the state voter.
package tmr_timeout_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    EXPIRE = 2'd3
  } state_e;

  localparam int unsigned StateW = 2;

endpackage

// File: rtl/tmr_timeout_ctrl_vote.sv
// Bitwise 2-of-3 majority voter.
// A, B, C : the three redundant copies (Width bits each)
// Y       : per-bit majority of A, B and C
module vote #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [Width-1:0] C,
  output logic [Width-1:0] Y
);

  assign Y = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/tmr_timeout_ctrl.sv
// Watchdog / gate-window controller for a triplicated counter.
// Votes the three counter copies, runs a clear/run/expire sequence against a
// limit captured at START, pulses TIMEOUT for one cycle at expiry and keeps a
// sticky flag for any disagreement between the counter copies.
// CLK, RST     : clock, synchronous active-high reset
// START        : open a window (accepted only in IDLE, ABORT low)
// ABORT        : cancel the window without TIMEOUT (ignored in EXPIRE)
// LIMIT        : terminal count, captured on the accepted START edge
// ERR_CLR      : clear SEU_ERR (a mismatch in the same cycle wins)
// Q1, Q2, Q3   : counter copies
// CNT_CE       : counter enable (RUN)
// CNT_RST      : counter clear (CLEAR)
// TIMEOUT      : one-cycle expiry pulse (EXPIRE)
// BUSY         : controller not idle
// COUNT        : majority of Q1/Q2/Q3
// SEU_ERR      : sticky copy-mismatch flag
module tmr_timeout_ctrl
  import tmr_timeout_ctrl_pkg::*;
#(
  parameter int unsigned Width = 4,
  parameter bit          TMR   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [Width-1:0] LIMIT,
  input  logic             ERR_CLR,
  input  logic [Width-1:0] Q1,
  input  logic [Width-1:0] Q2,
  input  logic [Width-1:0] Q3,
  output logic             CNT_CE,
  output logic             CNT_RST,
  output logic             TIMEOUT,
  output logic             BUSY,
  output logic [Width-1:0] COUNT,
  output logic             SEU_ERR
);

  localparam logic [Width-1:0] One = Width'(1);

  state_e           state_v;
  state_e           state_d;
  logic [Width-1:0] limit_v;
  logic [Width-1:0] limit_d;
  logic             mismatch;
  logic             seu_q;
  logic             seu_d;

  vote #(.Width(Width)) u_count_vote (
    .A(Q1),
    .B(Q2),
    .C(Q3),
    .Y(COUNT)
  );

  // RUN is only entered with a nonzero limit, so limit_v - 1 never wraps.
  always_comb begin
    state_d = state_v;
    limit_d = limit_v;
    unique case (state_v)
      IDLE: begin
        if (START && !ABORT) begin
          limit_d = LIMIT;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (ABORT)               state_d = IDLE;
        else if (limit_v == '0)  state_d = EXPIRE;
        else                     state_d = RUN;
      end
      RUN: begin
        if (ABORT)                        state_d = IDLE;
        else if (COUNT == limit_v - One)  state_d = EXPIRE;
      end
      EXPIRE: state_d = IDLE;
    endcase
  end

  // Every copy advances from the voted state, so a single corrupted copy is
  // overwritten on the next edge.
  if (TMR) begin : g_tmr
    (* syn_preserve = 1, preserve *) state_e           st0_q, st1_q, st2_q;
    (* syn_preserve = 1, preserve *) logic [Width-1:0] lim0_q, lim1_q, lim2_q;
    (* keep *) logic [StateW-1:0] st_vote;
    (* keep *) logic [Width-1:0]  lim_vote;

    always_ff @(posedge CLK) begin
      if (RST) begin
        st0_q  <= IDLE;
        st1_q  <= IDLE;
        st2_q  <= IDLE;
        lim0_q <= '0;
        lim1_q <= '0;
        lim2_q <= '0;
      end else begin
        st0_q  <= state_d;
        st1_q  <= state_d;
        st2_q  <= state_d;
        lim0_q <= limit_d;
        lim1_q <= limit_d;
        lim2_q <= limit_d;
      end
    end

    vote #(.Width(StateW)) u_state_vote (
      .A(st0_q),
      .B(st1_q),
      .C(st2_q),
      .Y(st_vote)
    );

    vote #(.Width(Width)) u_limit_vote (
      .A(lim0_q),
      .B(lim1_q),
      .C(lim2_q),
      .Y(lim_vote)
    );

    assign state_v = state_e'(st_vote);
    assign limit_v = lim_vote;
  end else begin : g_single
    state_e           st_q;
    logic [Width-1:0] lim_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        st_q  <= IDLE;
        lim_q <= '0;
      end else begin
        st_q  <= state_d;
        lim_q <= limit_d;
      end
    end

    assign state_v = st_q;
    assign limit_v = lim_q;
  end

  assign CNT_RST = (state_v == CLEAR);
  assign CNT_CE  = (state_v == RUN);
  assign TIMEOUT = (state_v == EXPIRE);
  assign BUSY    = (state_v != IDLE);

  assign mismatch = (Q1 != Q2) || (Q2 != Q3);

  always_comb begin
    seu_d = mismatch | (seu_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) seu_q <= 1'b0;
    else     seu_q <= seu_d;
  end

  assign SEU_ERR = seu_q;

endmodule
